// File: rtl/jtcps2_obj_draw.sv
// -----------------------------------------------------------------------------
// jtcps2_obj_draw
//   Object draw stage. Takes one 16-pixel tile row per handshake from the
//   object line scanner, fetches its two 32-bit planar ROM words (8 pixels
//   each), converts them to 4bpp pixels and writes the non-transparent ones
//   into the object line buffer.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   line_start    new line pulse, aborts the tile in progress
//   dr_start      latch dr_* (only honoured while dr_idle=1)
//   dr_idle       high only while the stage is idle
//   dr_code       tile code
//   dr_attr       [11:8] vsub, [5] hflip, [4:0] palette
//   dr_hpos       screen x of the leftmost pixel
//   dr_prio       object priority
//   dr_bank       object ROM bank
//   rom_addr      {bank, code, vsub, half}
//   rom_cs        ROM request, held until rom_ok accepted
//   rom_ok        ROM data valid
//   rom_data      planar word, 4 planes x 8 bits
//   buf_addr      line-buffer write address (wraps modulo 2**BUFW)
//   buf_data      {prio, pal, colour}
//   buf_wr        line-buffer write strobe
// -----------------------------------------------------------------------------
module jtcps2_obj_draw #(
    parameter logic [3:0] TRANSP = 4'hF,
    parameter int         BUFW   = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            line_start,
    input  logic            dr_start,
    output logic            dr_idle,
    input  logic [15:0]     dr_code,
    input  logic [15:0]     dr_attr,
    input  logic [8:0]      dr_hpos,
    input  logic [2:0]      dr_prio,
    input  logic [1:0]      dr_bank,
    output logic [22:0]     rom_addr,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [31:0]     rom_data,
    output logic [BUFW-1:0] buf_addr,
    output logic [11:0]     buf_data,
    output logic            buf_wr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAW} state_t;

    state_t          state_q, state_d;

    // Tile parameters latched at dr_start
    logic [15:0]     code_q, code_d;
    logic [3:0]      vsub_q, vsub_d;
    logic            hflip_q, hflip_d;
    logic [4:0]      pal_q, pal_d;
    logic [8:0]      hpos_q, hpos_d;
    logic [2:0]      prio_q, prio_d;
    logic [1:0]      bank_q, bank_d;

    // Draw progress
    logic            half_q, half_d;      // ROM half currently being fetched
    logic            second_q, second_d;  // 0: first fetched half, 1: second
    logic [2:0]      cnt_q, cnt_d;        // pixel within the half
    logic [31:0]     word_q, word_d;

    // Registered outputs
    logic [22:0]     rom_addr_q, rom_addr_d;
    logic            rom_cs_q, rom_cs_d;
    logic [BUFW-1:0] buf_addr_q, buf_addr_d;
    logic [11:0]     buf_data_q, buf_data_d;
    logic            buf_wr_q, buf_wr_d;

    logic [3:0]      colour;
    logic [3:0]      col;

    // Attribute bits this stage does not use
    logic            unused_attr;
    assign unused_attr = ^{dr_attr[15:12], dr_attr[7:6]};

    // Pixel c in screen order. Unflipped, the leftmost pixel is the MSB of
    // each plane byte; flipped, it is the LSB.
    function automatic logic [3:0] pix_colour(input logic [31:0] w,
                                              input logic [2:0]  c,
                                              input logic        hf);
        logic [2:0] idx;
        logic [7:0] p3, p2, p1, p0;
        idx = hf ? c : (3'd7 - c);
        p3  = w[31:24];
        p2  = w[23:16];
        p1  = w[15:8];
        p0  = w[7:0];
        return {p3[idx], p2[idx], p1[idx], p0[idx]};
    endfunction

    assign colour = pix_colour(word_q, cnt_q, hflip_q);
    // First fetched half always covers screen columns 0..7
    assign col    = {second_q, cnt_q};

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        vsub_d     = vsub_q;
        hflip_d    = hflip_q;
        pal_d      = pal_q;
        hpos_d     = hpos_q;
        prio_d     = prio_q;
        bank_d     = bank_q;
        half_d     = half_q;
        second_d   = second_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_wr_d   = 1'b0;

        if (line_start) begin
            // Abort wins over everything, including a coincident rom_ok
            state_d  = IDLE;
            rom_cs_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dr_start) begin
                        code_d     = dr_code;
                        vsub_d     = dr_attr[11:8];
                        hflip_d    = dr_attr[5];
                        pal_d      = dr_attr[4:0];
                        hpos_d     = dr_hpos;
                        prio_d     = dr_prio;
                        bank_d     = dr_bank;
                        half_d     = dr_attr[5];
                        second_d   = 1'b0;
                        rom_addr_d = {dr_bank, dr_code, dr_attr[11:8], dr_attr[5]};
                        rom_cs_d   = 1'b1;
                        state_d    = REQ;
                    end
                end
                // Address changed this cycle, so rom_ok here is stale
                REQ: state_d = WAIT;
                WAIT: begin
                    if (rom_ok) begin
                        word_d   = rom_data;
                        rom_cs_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = DRAW;
                    end
                end
                DRAW: begin
                    buf_addr_d = BUFW'(hpos_q) + BUFW'(col);
                    buf_data_d = {prio_q, pal_q, colour};
                    buf_wr_d   = (colour != TRANSP);
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (second_q) begin
                            state_d = IDLE;
                        end else begin
                            second_d   = 1'b1;
                            half_d     = ~half_q;
                            rom_addr_d = {bank_q, code_q, vsub_q, ~half_q};
                            rom_cs_d   = 1'b1;
                            state_d    = REQ;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            buf_wr_q   <= buf_wr_d;
        end
    end

    // Tile parameters and pixel word carry no reset: they are only read
    // after being loaded in IDLE/WAIT.
    always_ff @(posedge clk) begin
        code_q   <= code_d;
        vsub_q   <= vsub_d;
        hflip_q  <= hflip_d;
        pal_q    <= pal_d;
        hpos_q   <= hpos_d;
        prio_q   <= prio_d;
        bank_q   <= bank_d;
        half_q   <= half_d;
        second_q <= second_d;
        cnt_q    <= cnt_d;
        word_q   <= word_d;
    end

    assign dr_idle  = (state_q == IDLE);
    assign rom_addr = rom_addr_q;
    assign rom_cs   = rom_cs_q;
    assign buf_addr = buf_addr_q;
    assign buf_data = buf_data_q;
    assign buf_wr   = buf_wr_q;

endmodule
